// File: rtl/pushable_object_mover.sv
// Fixed-point mover for one pushable object (key, crate).
// IDLE/PUSH/PULL/BLOCKED motion FSM with border back-off and clamp.
module pushable_object_mover #(
  parameter int FRAC_BITS = 6,
  parameter int BACKOFF   = 64,
  parameter int POS_MAX_X = 639,
  parameter int POS_MAX_Y = 479,
  parameter int INIT_X    = 320,
  parameter int INIT_Y    = 240
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               startOfFrame,
  input  logic               loadPos,
  input  logic [10:0]        initX,
  input  logic [10:0]        initY,
  input  logic [3:0]         dirReq,
  input  logic signed [10:0] playerXspeed,
  input  logic signed [10:0] playerYspeed,
  input  logic               magnetMode,
  input  logic               hitPlayer,
  input  logic               hitWall,
  input  logic [3:0]         hitEdgeCode,
  output logic signed [10:0] topLeftX,
  output logic signed [10:0] topLeftY,
  output logic [3:0]         stopPlayer,
  output logic               moving
);

  localparam int PW = 11 + FRAC_BITS;
  localparam int SW = PW + 2;

  localparam logic [3:0] D_L = 4'b1000;
  localparam logic [3:0] D_U = 4'b0100;
  localparam logic [3:0] D_R = 4'b0010;
  localparam logic [3:0] D_D = 4'b0001;

  localparam logic signed [PW-1:0] RST_X =
    PW'(INIT_X * (2 ** FRAC_BITS));
  localparam logic signed [PW-1:0] RST_Y =
    PW'(INIT_Y * (2 ** FRAC_BITS));
  localparam int LIM_X = POS_MAX_X * (2 ** FRAC_BITS);
  localparam int LIM_Y = POS_MAX_Y * (2 ** FRAC_BITS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PUSH,
    S_PULL,
    S_BLOCKED
  } state_e;

  state_e                 state_q, state_d;
  logic [3:0]             dir_q, dir_d;
  logic signed [PW-1:0]   vel_x_q, vel_x_d;
  logic signed [PW-1:0]   vel_y_q, vel_y_d;
  logic signed [PW-1:0]   pos_x_q, pos_x_d;
  logic signed [PW-1:0]   pos_y_q, pos_y_d;
  logic [3:0]             stop_q, stop_d;

  logic [3:0]             cand;
  logic [3:0]             opp_dir;
  logic                   blk_entry;
  logic signed [SW-1:0]   sum_x;
  logic signed [SW-1:0]   sum_y;

  // Left<->Right and Up<->Down swap in {L,U,R,D} order.
  function automatic logic [3:0] opp(input logic [3:0] d);
    return {d[1], d[0], d[3], d[2]};
  endfunction

  function automatic logic signed [PW-1:0] sext(
    input logic signed [10:0] s
  );
    return {{(PW-11){s[10]}}, s};
  endfunction

  function automatic logic signed [PW-1:0] clamp(
    input logic signed [SW-1:0] v,
    input int                   lim
  );
    logic signed [PW-1:0] r;
    if (v < 0)
      r = '0;
    else if (v > lim)
      r = lim[PW-1:0];
    else
      r = v[PW-1:0];
    return r;
  endfunction

  assign opp_dir = opp(dir_q);

  // Contact edge picks the push direction; Left edge wins ties.
  always_comb begin
    cand = '0;
    if (hitEdgeCode[3])
      cand = D_R;
    else if (hitEdgeCode[2])
      cand = D_D;
    else if (hitEdgeCode[1])
      cand = D_L;
    else if (hitEdgeCode[0])
      cand = D_U;
  end

  always_comb begin
    state_d   = state_q;
    dir_d     = dir_q;
    vel_x_d   = vel_x_q;
    vel_y_d   = vel_y_q;
    pos_x_d   = pos_x_q;
    pos_y_d   = pos_y_q;
    stop_d    = stop_q;
    blk_entry = 1'b0;
    sum_x     = SW'(pos_x_q) + SW'(vel_x_q);
    sum_y     = SW'(pos_y_q) + SW'(vel_y_q);

    unique case (state_q)
      S_IDLE: begin
        vel_x_d = '0;
        vel_y_d = '0;
        if (hitPlayer && cand != 4'b0 && dirReq == cand) begin
          state_d = S_PUSH;
          dir_d   = cand;
          unique case (1'b1)
            cand[3]: vel_x_d = -sext(playerXspeed);
            cand[2]: vel_y_d = -sext(playerYspeed);
            cand[1]: vel_x_d =  sext(playerXspeed);
            cand[0]: vel_y_d =  sext(playerYspeed);
          endcase
        end
      end
      S_PUSH: begin
        if (hitWall && |(hitEdgeCode & dir_q)) begin
          blk_entry = 1'b1;
        end else if (dirReq == dir_q) begin
          state_d = S_PUSH;
        end else if (dirReq == opp_dir && magnetMode) begin
          state_d = S_PULL;
          dir_d   = opp_dir;
          vel_x_d = '0;
          vel_y_d = '0;
          unique case (1'b1)
            opp_dir[3]: vel_x_d = -sext(playerXspeed);
            opp_dir[2]: vel_y_d = -sext(playerYspeed);
            opp_dir[1]: vel_x_d =  sext(playerXspeed);
            opp_dir[0]: vel_y_d =  sext(playerYspeed);
            default: ;
          endcase
        end else begin
          state_d = S_IDLE;
          vel_x_d = '0;
          vel_y_d = '0;
        end
      end
      S_PULL: begin
        if (hitWall && |(hitEdgeCode & dir_q)) begin
          blk_entry = 1'b1;
        end else if (magnetMode && dirReq == dir_q) begin
          state_d = S_PULL;
        end else begin
          state_d = S_IDLE;
          vel_x_d = '0;
          vel_y_d = '0;
        end
      end
      S_BLOCKED: begin
        vel_x_d = '0;
        vel_y_d = '0;
        if (dirReq != 4'b0 && dirReq != dir_q) begin
          state_d = S_IDLE;
          stop_d  = '0;
        end
      end
    endcase

    // Back-off replaces integration on the blocking cycle.
    if (blk_entry) begin
      state_d = S_BLOCKED;
      vel_x_d = '0;
      vel_y_d = '0;
      stop_d  = dir_q;
      unique case (1'b1)
        dir_q[3]: pos_x_d = clamp(SW'(pos_x_q) + SW'(BACKOFF), LIM_X);
        dir_q[2]: pos_y_d = clamp(SW'(pos_y_q) + SW'(BACKOFF), LIM_Y);
        dir_q[1]: pos_x_d = clamp(SW'(pos_x_q) - SW'(BACKOFF), LIM_X);
        dir_q[0]: pos_y_d = clamp(SW'(pos_y_q) - SW'(BACKOFF), LIM_Y);
        default: ;
      endcase
    end else if (startOfFrame) begin
      pos_x_d = clamp(sum_x, LIM_X);
      pos_y_d = clamp(sum_y, LIM_Y);
    end

    if (loadPos) begin
      state_d = S_IDLE;
      dir_d   = '0;
      vel_x_d = '0;
      vel_y_d = '0;
      stop_d  = '0;
      pos_x_d = {initX, {FRAC_BITS{1'b0}}};
      pos_y_d = {initY, {FRAC_BITS{1'b0}}};
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q <= S_IDLE;
      dir_q   <= '0;
      vel_x_q <= '0;
      vel_y_q <= '0;
      pos_x_q <= RST_X;
      pos_y_q <= RST_Y;
      stop_q  <= '0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      vel_x_q <= vel_x_d;
      vel_y_q <= vel_y_d;
      pos_x_q <= pos_x_d;
      pos_y_q <= pos_y_d;
      stop_q  <= stop_d;
    end
  end

  assign topLeftX   = pos_x_q[PW-1:FRAC_BITS];
  assign topLeftY   = pos_y_q[PW-1:FRAC_BITS];
  assign stopPlayer = stop_q;
  assign moving     = (state_q == S_PUSH) || (state_q == S_PULL);

endmodule

// File: tb/tb_pushable_object_mover.sv
// Directed scoreboard bench for pushable_object_mover.
// Expectations queued at drive time, popped after the DUT responds.
module tb_pushable_object_mover;

  logic               clk = 1'b0;
  logic               resetN = 1'b0;
  logic               startOfFrame = 1'b0;
  logic               loadPos = 1'b0;
  logic [10:0]        initX = '0;
  logic [10:0]        initY = '0;
  logic [3:0]         dirReq = '0;
  logic signed [10:0] playerXspeed = 11'sd128;
  logic signed [10:0] playerYspeed = 11'sd128;
  logic               magnetMode = 1'b0;
  logic               hitPlayer = 1'b0;
  logic               hitWall = 1'b0;
  logic [3:0]         hitEdgeCode = '0;
  logic signed [10:0] topLeftX;
  logic signed [10:0] topLeftY;
  logic [3:0]         stopPlayer;
  logic               moving;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string      tag;
    int         x;
    int         y;
    logic [3:0] stop;
    logic       mov;
  } exp_t;

  exp_t expq[$];

  pushable_object_mover dut (
    .clk          (clk),
    .resetN       (resetN),
    .startOfFrame (startOfFrame),
    .loadPos      (loadPos),
    .initX        (initX),
    .initY        (initY),
    .dirReq       (dirReq),
    .playerXspeed (playerXspeed),
    .playerYspeed (playerYspeed),
    .magnetMode   (magnetMode),
    .hitPlayer    (hitPlayer),
    .hitWall      (hitWall),
    .hitEdgeCode  (hitEdgeCode),
    .topLeftX     (topLeftX),
    .topLeftY     (topLeftY),
    .stopPlayer   (stopPlayer),
    .moving       (moving)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic frame();
    startOfFrame = 1'b1;
    cyc(1);
    startOfFrame = 1'b0;
  endtask

  task automatic expect_st(input string tag, input int x, input int y,
                           input logic [3:0] stop, input logic mov);
    exp_t e;
    e.tag = tag;
    e.x = x;
    e.y = y;
    e.stop = stop;
    e.mov = mov;
    expq.push_back(e);
  endtask

  task automatic check();
    exp_t e;
    total++;
    assert (expq.size() != 0) else begin
      bad++;
      $error("FAIL scoreboard empty got=0 want=1");
    end
    if (expq.size() != 0) begin
      e = expq.pop_front();
      assert (int'(topLeftX) === e.x) else begin
        bad++;
        $error("FAIL %s x got=%0d want=%0d", e.tag, topLeftX, e.x);
      end
      assert (int'(topLeftY) === e.y) else begin
        bad++;
        $error("FAIL %s y got=%0d want=%0d", e.tag, topLeftY, e.y);
      end
      assert (stopPlayer === e.stop) else begin
        bad++;
        $error("FAIL %s stop got=%b want=%b", e.tag, stopPlayer, e.stop);
      end
      assert (moving === e.mov) else begin
        bad++;
        $error("FAIL %s moving got=%b want=%b", e.tag, moving, e.mov);
      end
    end
  endtask

  task automatic load(input int x, input int y);
    initX = 11'(x);
    initY = 11'(y);
    loadPos = 1'b1;
    cyc(1);
    loadPos = 1'b0;
  endtask

  task automatic contact(input logic [3:0] edg, input logic [3:0] dir);
    hitPlayer = 1'b1;
    hitEdgeCode = edg;
    dirReq = dir;
    cyc(1);
    hitPlayer = 1'b0;
    hitEdgeCode = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    cyc(2);
    expect_st("reset", 320, 240, 4'b0000, 1'b0);
    check();
    resetN = 1'b1;
    cyc(1);
    for (int i = 0; i < 10; i++) begin
      expect_st("idle_frame", 320, 240, 4'b0000, 1'b0);
      frame();
      check();
    end

    // push right at 2 px/frame
    expect_st("push_r_enter", 320, 240, 4'b0000, 1'b1);
    contact(4'b1000, 4'b0010);
    check();
    for (int i = 1; i <= 4; i++) begin
      expect_st("push_r_frame", 320 + 2 * i, 240, 4'b0000, 1'b1);
      frame();
      check();
    end
    expect_st("push_r_release", 328, 240, 4'b0000, 1'b0);
    dirReq = 4'b0000;
    cyc(1);
    check();
    expect_st("push_r_after", 328, 240, 4'b0000, 1'b0);
    frame();
    check();

    // magnet pull
    load(320, 240);
    contact(4'b1000, 4'b0010);
    frame();
    expect_st("pull_pre", 324, 240, 4'b0000, 1'b1);
    frame();
    check();
    magnetMode = 1'b1;
    dirReq = 4'b1000;
    expect_st("pull_enter", 324, 240, 4'b0000, 1'b1);
    cyc(1);
    check();
    for (int i = 1; i <= 3; i++) begin
      expect_st("pull_frame", 324 - 2 * i, 240, 4'b0000, 1'b1);
      frame();
      check();
    end
    dirReq = 4'b0000;
    expect_st("pull_release", 318, 240, 4'b0000, 1'b0);
    cyc(1);
    check();
    expect_st("pull_after", 318, 240, 4'b0000, 1'b0);
    frame();
    check();
    magnetMode = 1'b0;

    // wall block while pushing right
    load(600, 240);
    contact(4'b1000, 4'b0010);
    hitWall = 1'b1;
    hitEdgeCode = 4'b0010;
    expect_st("block_enter", 599, 240, 4'b0010, 1'b0);
    cyc(1);
    hitWall = 1'b0;
    hitEdgeCode = 4'b0000;
    check();
    expect_st("block_hold", 599, 240, 4'b0010, 1'b0);
    frame();
    check();
    dirReq = 4'b0100;
    expect_st("block_leave", 599, 240, 4'b0000, 1'b0);
    cyc(1);
    check();
    dirReq = 4'b0000;

    // clamp at left border
    load(1, 240);
    contact(4'b0010, 4'b1000);
    expect_st("clamp_f1", 0, 240, 4'b0000, 1'b1);
    frame();
    check();
    expect_st("clamp_f2", 0, 240, 4'b0000, 1'b1);
    frame();
    check();
    dirReq = 4'b0000;
    cyc(1);

    // push down at 3 px/frame
    load(100, 100);
    playerYspeed = 11'sd192;
    contact(4'b0100, 4'b0001);
    expect_st("push_down", 100, 103, 4'b0000, 1'b1);
    frame();
    check();
    dirReq = 4'b0000;
    cyc(1);

    // multi-edge priority: Left edge wins, wants Right, so Left request idles
    load(200, 200);
    contact(4'b1010, 4'b1000);
    expect_st("edge_prio", 200, 200, 4'b0000, 1'b0);
    frame();
    check();
    dirReq = 4'b0000;

    // reversal without magnet drops to idle
    contact(4'b1000, 4'b0010);
    dirReq = 4'b1000;
    expect_st("rev_no_magnet", 200, 200, 4'b0000, 1'b0);
    cyc(1);
    check();
    dirReq = 4'b0000;

    // loadPos beats concurrent frame strobe and contact
    load(100, 100);
    contact(4'b1000, 4'b0010);
    frame();
    initX = 11'd50;
    initY = 11'd60;
    loadPos = 1'b1;
    startOfFrame = 1'b1;
    hitPlayer = 1'b1;
    hitEdgeCode = 4'b1000;
    expect_st("load_mid_push", 50, 60, 4'b0000, 1'b0);
    cyc(1);
    loadPos = 1'b0;
    startOfFrame = 1'b0;
    hitPlayer = 1'b0;
    hitEdgeCode = 4'b0000;
    check();
    expect_st("load_after", 50, 60, 4'b0000, 1'b0);
    frame();
    check();
    dirReq = 4'b0000;

    // async reset mid-pull
    load(300, 200);
    contact(4'b1000, 4'b0010);
    magnetMode = 1'b1;
    dirReq = 4'b1000;
    cyc(1);
    frame();
    #2;
    resetN = 1'b0;
    expect_st("async_reset", 320, 240, 4'b0000, 1'b0);
    #1;
    check();
    magnetMode = 1'b0;
    dirReq = 4'b0000;
    cyc(1);
    resetN = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
